framebuffer_scanout: RTL
========================

# framebuffer_scanout

Single-clock framebuffer stage between the camera write path and the VGA output. Owns the one SB_SPRAM256KA framebuffer through its native port and stores a 160x120, 6-bit-per-pixel image, two pixels per 16-bit word. Scans the image out 4x upscaled to 640x480, taking its position from the `vga` timing block. Replaces `pattern_gen` on `RGB`. Accepts pixel writes from the camera side, already in the `clk` domain, through a valid/ready handshake, interleaved with scanout reads.

## Interface
Parameters:
- FB_W, 160, framebuffer width in pixels (even)
- FB_H, 120, framebuffer height in lines
- PIPE_LAT, 3, scanout latency in clocks (fixed; documents alignment)

Ports:
- clk  in  1  25 MHz pixel clock (clk_25MHz)
- rst  in  1  synchronous, active-high reset
- vga_valid  in  1  visible-region flag from `vga`
- vga_row  in  10  current row, 0..479
- vga_col  in  10  current column, 0..639
- hsync_in  in  1  HSYNC from `vga`
- vsync_in  in  1  VSYNC from `vga`
- RGB  out  6  pixel to DAC
- hsync_out  out  1  HSYNC delayed to align with RGB
- vsync_out  out  1  VSYNC delayed to align with RGB
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted this cycle when high with wr_valid
- wr_x  in  8  pixel column, 0..FB_W-1
- wr_y  in  7  pixel line, 0..FB_H-1
- wr_data  in  6  pixel value
- spram_addr  out  14  SPRAM ADDRESS
- spram_din  out  16  SPRAM DATAIN
- spram_mask  out  4  SPRAM MASKWREN
- spram_wren  out  1  SPRAM WREN
- spram_dout  in  16  SPRAM DATAOUT; valid 1 clk after read address

## Operation
- Address map: word = y*80 + (x>>1). x[0]=0 is the low byte and x[0]=1 is the high byte. Pixel occupies bits [5:0] of its byte, and bits [7:6] are 0. Max word is 9599.
- Scanout stage s1 registers vga_valid, vga_row, vga_col, hsync_in and vsync_in. It derives y=row>>2 and x=col>>2.
- Read slot: s1_valid && s1_col[2:0]==0, which gives one read per 8 columns.
  - In a read slot, spram_addr is the scan address, spram_wren=0 and spram_mask=4'b1111.
- Stage s2 carries a flag marking that the previous cycle was a read. When set, spram_dout is captured into word_reg.
  - The pixel is selected from spram_dout on the capture cycle and from word_reg otherwise.
  - The byte is chosen by x[0], which is col[2].
- Stage s3 registers RGB. RGB = 0 when the delayed valid is low.
- Write path:
  - wr_ready = !rst && !read_slot.
  - On accept, spram_addr is the write address and spram_din = {2'b0,wr_data,2'b0,wr_data}.
  - spram_mask = 4'b0011 when wr_x[0]=0, and 4'b1100 when wr_x[0]=1.
  - spram_wren = 1 only if wr_x<FB_W && wr_y<FB_H.
  - An out-of-range request is still accepted, and its data is dropped.
- With no read and no accepted write, spram_wren=0 and spram_addr holds its last value.
- The framebuffer is not cleared by rst. SPRAM contents persist.

## Timing
- Reset values: RGB=0, hsync_out=1, vsync_out=1, wr_ready=0, spram_wren=0, spram_addr=0, spram_mask=0, word_reg=0. All s1..s3 valid flags are 0.
- Latency: inputs sampled at edge k produce RGB, hsync_out and vsync_out at edge k+3.
- The write handshake is combinational on read_slot. A write is never stalled more than 1 consecutive cycle during the active region, and never stalled in blanking.
- Simultaneous read slot and wr_valid: the read wins, wr_ready=0, and the writer must hold its request.
- A write to the word being scanned in the same line is visible from the next read of that word. Partial tearing is permitted.
- At col 639→0 wrap and at row change, no special handling is needed. Each 8-column group re-reads its word.
- rst asserted mid-frame: outputs go to reset values at the next edge. Scanout resumes correctly from the next vga_valid sample, with the 3-clk pipeline refill.

## Structure
- Package fb_pkg holds FB_W, FB_H, WORDS_PER_LINE=80, MASK_LO=4'b0011, MASK_HI=4'b1100 and the byte-packing helper constants.
- Sub-module fb_addr_calc is combinational: y*80 computed as (y<<6)+(y<<4), plus x>>1. It is instantiated twice, once for scan and once for write.
- The SPRAM instance lives in `top`, wired to the spram_* ports with CHIPSELECT=1, STANDBY=0, SLEEP=0, POWEROFF=1.

## Test plan
- Write x=0,y=0 data 6'h2A, then x=1,y=0 data 6'h15, then scan row 0..3 col 0..7:
  - the SPRAM model shows word 0 = 16'h152A;
  - RGB=6'h2A for cols 0..3 and 6'h15 for cols 4..7, each 3 clks after input.
- wr_valid held high across an active line: wr_ready is low exactly at col%8==0 samples. No write is lost, and every accepted write appears in the model.
- Write x=159,y=119 data 6'h3F: word 9599 high byte = 8'h3F. Scanning row 476..479 col 636..639 gives RGB=6'h3F.
- Write x=160,y=5 and x=3,y=120: both are accepted, and spram_wren stays 0.
- With vga_valid low: RGB=0, and hsync_out/vsync_out equal hsync_in/vsync_in delayed by exactly 3 clks.
- Assert rst for 1 clk mid-line:
  - next edge: RGB=0, syncs=1, wr_ready=0;
  - after release, correct pixels resume 3 clks after the first sampled input.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and byte-packing helpers for the framebuffer scanout stage.
package fb_pkg;
    localparam int FB_W           = 160;
    localparam int FB_H           = 120;
    localparam int WORDS_PER_LINE = 80;
    localparam int PIX_W          = 6;
    localparam int BYTE_W         = 8;

    // MASKWREN bits each cover one nibble of the 16-bit word
    localparam logic [3:0] MASK_LO  = 4'b0011;
    localparam logic [3:0] MASK_HI  = 4'b1100;
    localparam logic [3:0] MASK_ALL = 4'b1111;

    // Pixel replicated into both bytes; the mask decides which byte lands
    function automatic logic [15:0] pack_pixel(input logic [PIX_W-1:0] d);
        return {2'b00, d, 2'b00, d};
    endfunction

    // Low byte holds the even pixel, high byte the odd pixel
    function automatic logic [PIX_W-1:0] pick_pixel(input logic [15:0] w, input logic hi);
        return hi ? w[BYTE_W +: PIX_W] : w[0 +: PIX_W];
    endfunction
endpackage

// File: rtl/fb_addr_calc.sv
// Pixel coordinate to SPRAM word address: y*80 + x/2.
module fb_addr_calc
    import fb_pkg::*;
(
    input  logic [6:0]  y,
    input  logic [7:0]  x,
    output logic [13:0] addr
);

    // y*80 as two shifts (64+16) keeps this a pair of adders, no multiplier
    always_comb begin
        addr = (14'(y) << 6) + (14'(y) << 4) + 14'(x >> 1);
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer stage: 4x upscaled scanout of a 160x120x6 image held two pixels
// per SPRAM word, with camera writes slotted between the scanout reads.
module framebuffer_scanout #(
    parameter int FB_W     = fb_pkg::FB_W,
    parameter int FB_H     = fb_pkg::FB_H,
    parameter int PIPE_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vga_valid,
    input  logic [9:0]  vga_row,
    input  logic [9:0]  vga_col,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [5:0]  RGB,
    output logic        hsync_out,
    output logic        vsync_out,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_x,
    input  logic [6:0]  wr_y,
    input  logic [5:0]  wr_data,
    output logic [13:0] spram_addr,
    output logic [15:0] spram_din,
    output logic [3:0]  spram_mask,
    output logic        spram_wren,
    input  logic [15:0] spram_dout
);
    import fb_pkg::*;

    localparam logic [7:0] X_LIM = 8'(FB_W);
    localparam logic [6:0] Y_LIM = 7'(FB_H);

    // s1: registered VGA position
    logic       s1_valid;
    logic [9:0] s1_row, s1_col;
    // s2: read-issued flag and byte select
    logic       s2_valid, s2_rd, s2_x0;
    // sync delay lines, length matches the s1..s3 data pipeline
    logic [PIPE_LAT-1:0] hs_pipe, vs_pipe;

    logic [15:0] word_reg;
    logic [13:0] addr_q;
    logic [3:0]  mask_q;
    logic [13:0] scan_addr, wr_addr;
    logic        read_slot, wr_accept, wr_in_range;
    logic [5:0]  pix;

    fb_addr_calc u_scan_addr (
        .y    (7'(s1_row >> 2)),
        .x    (8'(s1_col >> 2)),
        .addr (scan_addr)
    );

    fb_addr_calc u_wr_addr (
        .y    (wr_y),
        .x    (wr_x),
        .addr (wr_addr)
    );

    // One word read per 8 columns covers two 4x-wide pixels
    assign read_slot   = s1_valid && (s1_col[2:0] == 3'd0);
    assign wr_ready    = !rst && !read_slot;
    assign wr_accept   = wr_valid && wr_ready;
    assign wr_in_range = (wr_x < X_LIM) && (wr_y < Y_LIM);
    assign spram_din   = pack_pixel(wr_data);

    // SPRAM port arbitration: read slot wins, else accepted write, else hold
    always_comb begin
        spram_addr = addr_q;
        spram_mask = mask_q;
        spram_wren = 1'b0;
        if (read_slot) begin
            spram_addr = scan_addr;
            spram_mask = MASK_ALL;
        end else if (wr_accept) begin
            spram_addr = wr_addr;
            spram_mask = wr_x[0] ? MASK_HI : MASK_LO;
            spram_wren = wr_in_range;
        end
    end

    // Holding registers so address/mask stay put on idle cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            mask_q <= '0;
        end else begin
            addr_q <= spram_addr;
            mask_q <= spram_mask;
        end
    end

    // Sync delay lines idle high
    always_ff @(posedge clk) begin
        if (rst) begin
            hs_pipe <= '1;
            vs_pipe <= '1;
        end else begin
            hs_pipe <= {hs_pipe[PIPE_LAT-2:0], hsync_in};
            vs_pipe <= {vs_pipe[PIPE_LAT-2:0], vsync_in};
        end
    end

    assign hsync_out = hs_pipe[PIPE_LAT-1];
    assign vsync_out = vs_pipe[PIPE_LAT-1];

    // s1/s2 position pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_row   <= '0;
            s1_col   <= '0;
            s2_valid <= 1'b0;
            s2_rd    <= 1'b0;
            s2_x0    <= 1'b0;
        end else begin
            s1_valid <= vga_valid;
            s1_row   <= vga_row;
            s1_col   <= vga_col;
            s2_valid <= s1_valid;
            s2_rd    <= read_slot;
            s2_x0    <= s1_col[2];
        end
    end

    // Fresh SPRAM data on the capture cycle, the held word for the other 7 columns
    assign pix = pick_pixel(s2_rd ? spram_dout : word_reg, s2_x0);

    // s3: output pixel and word capture
    always_ff @(posedge clk) begin
        if (rst) begin
            RGB      <= '0;
            word_reg <= '0;
        end else begin
            RGB <= s2_valid ? pix : 6'd0;
            if (s2_rd) word_reg <= spram_dout;
        end
    end

endmodule
